// File: rtl/axis_fifo_s_rx.sv
// AXI4-Stream slave receiver: buffers accepted beats in a single-clock FWFT FIFO,
// checks fixed-length framing (TLAST position, TKEEP) and reports frame counts and sticky errors.
module axis_fifo_s_rx #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH           = 1024,
    parameter int LENGTH_OF_FRAME      = 1024,
    parameter int FRAME_CNT_WIDTH      = 16
) (
    input  logic                                s_axis_aclk,
    input  logic                                s_axis_aresetn,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                                s_axis_tlast,
    input  logic                                rd_en,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]     dout,
    output logic                                dout_last,
    output logic                                empty,
    output logic [$clog2(FIFO_DEPTH):0]         data_count,
    output logic                                frame_done,
    output logic [FRAME_CNT_WIDTH-1:0]          frame_cnt,
    input  logic                                err_clr,
    output logic                                err_early_last,
    output logic                                err_missing_last,
    output logic                                err_keep
);

    localparam int W  = C_S_AXIS_TDATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(LENGTH_OF_FRAME);

    // A set condition on the same edge beats a clear request.
    function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
        return set | (cur & ~clr);
    endfunction

    function automatic logic [CW-1:0] count_next(input logic [CW-1:0] cnt,
                                                 input logic inc, input logic dec);
        logic [CW-1:0] res;
        res = cnt;
        if (inc && !dec)
            res = cnt + CW'(1);
        else if (dec && !inc)
            res = cnt - CW'(1);
        return res;
    endfunction

    logic [W:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count_nxt;
    logic [BW-1:0] beat_idx;
    logic [W:0]    head_nxt;
    logic          accept;
    logic          pop;
    logic          bypass;
    logic          last_beat;
    logic          keep_bad;

    // Stage 0: handshake decode and next-state of the FIFO bookkeeping
    always_comb begin
        accept     = s_axis_tvalid & s_axis_tready;
        pop        = rd_en & ~empty;
        count_nxt  = count_next(data_count, accept, pop);
        rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
        // The incoming beat becomes the head when nothing else survives this edge.
        bypass     = accept & (data_count == (pop ? CW'(1) : CW'(0)));
        head_nxt   = bypass ? {s_axis_tlast, s_axis_tdata} : mem[rd_ptr_nxt];
        last_beat  = (beat_idx == BW'(LENGTH_OF_FRAME - 1));
        keep_bad   = ~(&s_axis_tkeep);
    end

    // Storage array carries no reset; only its pointers do.
    always_ff @(posedge s_axis_aclk) begin
        if (accept)
            mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
    end

    // Stage 1: registered FIFO control, FWFT head and ready
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            s_axis_tready <= 1'b0;
            empty         <= 1'b1;
            data_count    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            dout          <= '0;
            dout_last     <= 1'b0;
        end else begin
            s_axis_tready <= (count_nxt < CW'(FIFO_DEPTH));
            empty         <= (count_nxt == '0);
            data_count    <= count_nxt;
            rd_ptr        <= rd_ptr_nxt;
            if (accept)
                wr_ptr <= wr_ptr + AW'(1);
            if (count_nxt != '0)
                {dout_last, dout} <= head_nxt;
        end
    end

    // Stage 1: frame structure tracking, counters and sticky errors
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            beat_idx         <= '0;
            frame_done       <= 1'b0;
            frame_cnt        <= '0;
            err_early_last   <= 1'b0;
            err_missing_last <= 1'b0;
            err_keep         <= 1'b0;
        end else begin
            if (accept) begin
                // Either a TLAST or reaching the fixed length closes the frame.
                if (s_axis_tlast || last_beat)
                    beat_idx <= '0;
                else
                    beat_idx <= beat_idx + BW'(1);
            end
            frame_done       <= accept & s_axis_tlast;
            frame_cnt        <= frame_cnt + FRAME_CNT_WIDTH'(accept & s_axis_tlast);
            err_early_last   <= sticky_next(err_early_last,
                                            accept & s_axis_tlast & ~last_beat, err_clr);
            err_missing_last <= sticky_next(err_missing_last,
                                            accept & ~s_axis_tlast & last_beat, err_clr);
            err_keep         <= sticky_next(err_keep, accept & keep_bad, err_clr);
        end
    end

endmodule

// File: tb/tb_axis_fifo_s_rx.sv
// Randomised and directed bench for axis_fifo_s_rx with a queue scoreboard and
// a frame-rule reference model evaluated on the falling edge.
module tb_axis_fifo_s_rx;

    localparam int W   = 32;
    localparam int D   = 16;
    localparam int L   = 4;
    localparam int FCW = 16;
    localparam int CW  = $clog2(D) + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           tvalid = 1'b0;
    logic           tready;
    logic [W-1:0]   tdata = '0;
    logic [3:0]     tkeep = 4'hF;
    logic           tlast = 1'b0;
    logic           rd_en = 1'b0;
    logic [W-1:0]   dout;
    logic           dout_last;
    logic           empty;
    logic [CW-1:0]  data_count;
    logic           frame_done;
    logic [FCW-1:0] frame_cnt;
    logic           err_clr = 1'b0;
    logic           err_early_last;
    logic           err_missing_last;
    logic           err_keep;

    always #5 clk = ~clk;

    axis_fifo_s_rx #(
        .C_S_AXIS_TDATA_WIDTH(W),
        .FIFO_DEPTH(D),
        .LENGTH_OF_FRAME(L),
        .FRAME_CNT_WIDTH(FCW)
    ) dut (
        .s_axis_aclk(clk),
        .s_axis_aresetn(rst_n),
        .s_axis_tvalid(tvalid),
        .s_axis_tready(tready),
        .s_axis_tdata(tdata),
        .s_axis_tkeep(tkeep),
        .s_axis_tlast(tlast),
        .rd_en(rd_en),
        .dout(dout),
        .dout_last(dout_last),
        .empty(empty),
        .data_count(data_count),
        .frame_done(frame_done),
        .frame_cnt(frame_cnt),
        .err_clr(err_clr),
        .err_early_last(err_early_last),
        .err_missing_last(err_missing_last),
        .err_keep(err_keep)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // Reference model state: expected FIFO contents and frame bookkeeping.
    logic [W:0]     q[$];
    int             pos = 0;
    logic           e_early = 0, e_miss = 0, e_keep = 0, e_done = 0;
    logic [FCW-1:0] e_fc = '0;
    bit             seen = 0;

    always @(posedge clk) seen = rst_n;

    always @(negedge clk) begin
        logic acc, pp, s_early, s_miss, s_keep;
        if (!rst_n) begin
            chk("rst_tready", 64'(tready), 64'(0));
            chk("rst_empty", 64'(empty), 64'(1));
            chk("rst_count", 64'(data_count), 64'(0));
            chk("rst_dout", 64'({dout_last, dout}), 64'(0));
            chk("rst_frame", 64'({frame_done, frame_cnt}), 64'(0));
            chk("rst_errs", 64'({err_early_last, err_missing_last, err_keep}), 64'(0));
            q.delete();
            pos = 0; e_early = 0; e_miss = 0; e_keep = 0; e_done = 0; e_fc = '0;
        end else begin
            chk("data_count", 64'(data_count), 64'(q.size()));
            chk("empty", 64'(empty), 64'(q.size() == 0));
            if (q.size() > 0)
                chk("dout", 64'({dout_last, dout}), 64'(q[0]));
            if (seen)
                chk("tready", 64'(tready), 64'(q.size() < D));
            chk("frame_done", 64'(frame_done), 64'(e_done));
            chk("frame_cnt", 64'(frame_cnt), 64'(e_fc));
            chk("err_early_last", 64'(err_early_last), 64'(e_early));
            chk("err_missing_last", 64'(err_missing_last), 64'(e_miss));
            chk("err_keep", 64'(err_keep), 64'(e_keep));

            acc = tvalid && tready;
            pp  = rd_en && !empty;
            s_early = 0; s_miss = 0; s_keep = 0;
            if (pp && q.size() > 0)
                void'(q.pop_front());
            if (acc) begin
                q.push_back({tlast, tdata});
                s_early = tlast && (pos + 1 < L);
                s_miss  = !tlast && (pos + 1 == L);
                s_keep  = (tkeep != 4'hF);
                pos = (tlast || pos + 1 == L) ? 0 : pos + 1;
            end
            e_done = acc && tlast;
            if (e_done)
                e_fc = e_fc + 1'b1;
            e_early = s_early ? 1'b1 : (err_clr ? 1'b0 : e_early);
            e_miss  = s_miss  ? 1'b1 : (err_clr ? 1'b0 : e_miss);
            e_keep  = s_keep  ? 1'b1 : (err_clr ? 1'b0 : e_keep);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [W-1:0] d, input logic last, input logic [3:0] keep);
        bit ok;
        ok = 0;
        tvalid = 1'b1; tdata = d; tlast = last; tkeep = keep;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (tready) begin
                ok = 1;
                break;
            end
        end
        if (!ok)
            chk("accept_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic fbeat(input logic [W-1:0] d);
        beat(d, pos == L - 1, 4'hF);
    endtask

    task automatic idle();
        tvalid = 1'b0; tlast = 1'b0; tkeep = 4'hF;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        idle();
        rd_en = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (empty) begin
                ok = 1;
                break;
            end
        end
        if (!ok)
            chk("drain_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nacc;
        logic [FCW-1:0] fc0;
        #1 rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);

        // Basic frame, then pop it out in order.
        fbeat(32'h11); fbeat(32'h22); fbeat(32'h33); fbeat(32'h44);
        idle();
        cyc(2);
        chk("basic_count", 64'(data_count), 64'(4));
        chk("basic_frame_cnt", 64'(frame_cnt), 64'(1));
        chk("basic_head", 64'({dout_last, dout}), 64'(33'h0_0000_0011));
        chk("basic_errs", 64'({err_early_last, err_missing_last, err_keep}), 64'(0));
        rd_en = 1'b1;
        cyc(4);
        rd_en = 1'b0;
        chk("basic_empty", 64'(empty), 64'(1));

        // Fill to full under backpressure, then one pop lets beat 17 in.
        nacc = 0;
        for (int i = 0; i < 20; i++) begin
            bit ok;
            tvalid = 1'b1; tdata = 32'h100 + nacc; tlast = (pos == L - 1); tkeep = 4'hF;
            @(negedge clk);
            ok = tready;
            @(posedge clk);
            #1;
            if (ok) nacc++;
        end
        chk("full_accepts", 64'(nacc), 64'(16));
        chk("full_tready", 64'(tready), 64'(0));
        chk("full_count", 64'(data_count), 64'(16));
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
        chk("pop_raises_tready", 64'(tready), 64'(1));
        fbeat(32'h100 + nacc);
        idle();
        cyc(1);
        chk("refill_count", 64'(data_count), 64'(16));
        drain();

        // Continuous streaming with one entry resident, across pointer wrap.
        fbeat($urandom);
        rd_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            fbeat($urandom);
            chk("stream_count", 64'(data_count), 64'(1));
            chk("stream_not_empty", 64'(empty), 64'(0));
        end
        drain();

        // Framing errors.
        rd_en = 1'b1;
        while (pos != 0) fbeat($urandom);
        clear_errs();
        fc0 = e_fc;
        beat(32'hA1, 1'b0, 4'hF); beat(32'hA2, 1'b1, 4'hF);
        idle(); cyc(1);
        chk("early_err", 64'(err_early_last), 64'(1));
        chk("early_frame_cnt", 64'(frame_cnt), 64'(fc0 + 1'b1));
        for (int i = 0; i < 4; i++) beat(32'hB0 + i, 1'b0, 4'hF);
        idle(); cyc(1);
        chk("missing_err", 64'(err_missing_last), 64'(1));
        chk("missing_frame_cnt", 64'(frame_cnt), 64'(fc0 + 1'b1));
        for (int i = 0; i < 4; i++) fbeat(32'hC0 + i);
        idle(); cyc(1);
        chk("good_frame_cnt", 64'(frame_cnt), 64'(fc0 + 2'd2));
        chk("good_no_keep", 64'(err_keep), 64'(0));
        clear_errs();
        chk("clr_errs", 64'({err_early_last, err_missing_last}), 64'(0));

        // TKEEP error and the set-beats-clear race.
        beat(32'hD0, pos == L - 1, 4'b0111);
        idle(); cyc(1);
        chk("keep_err", 64'(err_keep), 64'(1));
        err_clr = 1'b1;
        beat(32'hD1, pos == L - 1, 4'b0111);
        err_clr = 1'b0;
        idle();
        chk("keep_set_wins", 64'(err_keep), 64'(1));
        clear_errs();
        chk("keep_cleared", 64'(err_keep), 64'(0));
        drain();

        // Randomised traffic: a filling phase, then a draining phase.
        for (int i = 0; i < 400; i++) begin
            tvalid  = ($urandom % 4) != 0;
            tdata   = $urandom;
            tlast   = ($urandom % 4) == 0;
            tkeep   = (($urandom % 6) == 0) ? 4'($urandom) : 4'hF;
            rd_en   = (i < 200) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            err_clr = ($urandom % 20) == 0;
            cyc(1);
        end
        err_clr = 1'b0;
        drain();

        // Reset with five entries buffered and the beat index at 2.
        clear_errs();
        rd_en = 1'b1;
        while (pos != 1) fbeat($urandom);
        drain();
        for (int i = 0; i < 5; i++) fbeat(32'hE0 + i);
        idle();
        cyc(1);
        chk("pre_reset_count", 64'(data_count), 64'(5));
        chk("pre_reset_pos", 64'(pos), 64'(2));
        rst_n = 1'b0;
        #1;
        chk("mid_reset_empty", 64'(empty), 64'(1));
        chk("mid_reset_count", 64'(data_count), 64'(0));
        chk("mid_reset_tready", 64'(tready), 64'(0));
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        for (int i = 0; i < 4; i++) fbeat(32'hF0 + i);
        idle();
        cyc(2);
        chk("post_reset_errs", 64'({err_early_last, err_missing_last, err_keep}), 64'(0));
        chk("post_reset_frame_cnt", 64'(frame_cnt), 64'(1));
        chk("post_reset_count", 64'(data_count), 64'(4));
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/axis_fifo_s_rx.md
Name: axis_fifo_s_rx

Overview:
- AXI4-Stream slave receiver that buffers accepted beats in an internal single-clock FWFT FIFO and presents them to user logic through a read port.
- It is the receive-side counterpart of the team's FIFO-fed AXIS master. It sits at the PL ingress of a DMA/stream path.
- It checks frame structure: fixed LENGTH_OF_FRAME beats per frame, with TLAST on the final beat and all TKEEP bits set.
- It reports frame counts and sticky protocol errors.

Parameters:
- C_S_AXIS_TDATA_WIDTH, 32: stream and FIFO data width, in bits; must be a multiple of 8.
- FIFO_DEPTH, 1024: FIFO entries; power of 2, minimum 16.
- LENGTH_OF_FRAME, 1024: expected beats per frame; minimum 2.
- FRAME_CNT_WIDTH, 16: width of the frame counter.

Ports:
- s_axis_aclk  in  1  sole clock.
- s_axis_aresetn  in  1  asynchronous active-low reset.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.
- s_axis_tdata  in  C_S_AXIS_TDATA_WIDTH  stream data.
- s_axis_tkeep  in  C_S_AXIS_TDATA_WIDTH/8  byte qualifiers.
- s_axis_tlast  in  1  end of frame.
- rd_en  in  1  user pop request.
- dout  out  C_S_AXIS_TDATA_WIDTH  FWFT head data.
- dout_last  out  1  TLAST stored with the head entry.
- empty  out  1  FIFO empty.
- data_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- frame_done  out  1  one-cycle pulse on each accepted TLAST beat.
- frame_cnt  out  FRAME_CNT_WIDTH  count of accepted TLAST beats; wraps.
- err_clr  in  1  synchronous clear of sticky errors.
- err_early_last  out  1  sticky: TLAST seen before beat LENGTH_OF_FRAME.
- err_missing_last  out  1  sticky: no TLAST on beat LENGTH_OF_FRAME.
- err_keep  out  1  sticky: accepted beat with any TKEEP bit low.

Behaviour:
- Reset (asynchronous assert, synchronous release by the clock edge), all outputs:
  - s_axis_tready=0, empty=1, dout=0, dout_last=0, data_count=0.
  - frame_done=0, frame_cnt=0, all errors 0.
  - Internal beat counter beat_idx=0; FIFO pointers=0.
- Ready:
  - s_axis_tready is registered: 1 in the first cycle after reset release when data_count<FIFO_DEPTH.
  - Thereafter it equals (next data_count < FIFO_DEPTH).
  - It never depends combinationally on tvalid.
- Accept: accept = tvalid & tready. On accept, {tlast, tdata} is written; TKEEP is checked but not stored.
- Pop: pop = rd_en & ~empty. rd_en while empty is ignored and has no side effects.
- FWFT timing: with the FIFO empty, a beat accepted at edge N drives empty=0 and dout/dout_last valid after edge N. This is one-cycle latency; no read is needed.
- Pop at edge N presents the next entry after edge N, or sets empty=1 if none remains.
- data_count: +1 on accept only, −1 on pop only, unchanged on simultaneous accept and pop.
- Full: data_count=FIFO_DEPTH forces tready=0 and no writes occur. A pop while full raises tready after that edge.
- Simultaneous accept and pop when data_count=1 gives a continuous stream: empty stays 0.
- Pointers wrap modulo FIFO_DEPTH.
- Frame check, per accept, with last_beat = (beat_idx==LENGTH_OF_FRAME−1):
  - tlast & ~last_beat: set err_early_last; beat_idx←0.
  - ~tlast & last_beat: set err_missing_last; beat_idx←0 (resynchronise at the fixed length).
  - tlast & last_beat: beat_idx←0.
  - Otherwise: beat_idx←beat_idx+1.
  - In all cases the beat is still stored.
- TLAST beats: each accepted TLAST beat, early or not, pulses frame_done the following cycle (registered) and increments frame_cnt, wrapping to 0.
- err_keep: set on an accepted beat whose tkeep is not all ones.
- Error precedence: err_clr clears all sticky errors in the cycle after it is sampled, but a set condition in the same edge wins (set > clear).
- Reset mid-frame: FIFO contents and beat_idx are discarded and everything returns to reset values. The first beat after reset is treated as beat 0.

Test Plan:
- Basic frame: reset, LENGTH_OF_FRAME=4, send 4 beats 0x11..0x44 (TLAST on the 4th), rd_en=0.
  - Expect data_count=4, frame_done one pulse, frame_cnt=1, no errors.
  - Then rd_en=1 for 4 cycles: dout 0x11,0x22,0x33,0x44; dout_last=1 only on 0x44; then empty=1.
- Full/backpressure: FIFO_DEPTH=16, rd_en=0, tvalid held high for 20 cycles.
  - Expect exactly 16 accepts, tready=0 afterwards, data_count=16.
  - One pop gives tready=1 next cycle and beat 17 is accepted.
- Streaming: tvalid=1 and rd_en=1 continuously with 1 entry present. Expect data_count stays 1, empty never asserts, and data order is preserved across pointer wrap (>2×FIFO_DEPTH beats).
- Framing errors, LENGTH_OF_FRAME=4:
  - TLAST on beat 2: err_early_last=1, frame_cnt=1.
  - Next frame of 4 beats with no TLAST: err_missing_last=1, frame_cnt unchanged.
  - Following correct frame: no new errors.
  - Pulse err_clr: both errors return to 0.
- TKEEP and clear race: beat with tkeep=4'b0111 gives err_keep=1. A keep-error beat accepted in the same cycle as err_clr leaves err_keep=1.
- Reset mid-operation: assert s_axis_aresetn=0 with 5 entries buffered and beat_idx=2.
  - Expect immediately empty=1, data_count=0, tready=0.
  - After release, a 4-beat frame completes with no errors.
